// File: rtl/sym_pkg.sv
// Symbol encoding, decoder state type and small helpers shared by the
// Fs/address/X0/data/Fe symbol channel decoder.
package sym_pkg;
   localparam int SYM_W    = 5;
   localparam int SYM_FS   = 4;
   localparam int SYM_X0   = 3;
   localparam int SYM_FE   = 2;
   localparam int SYM_ONE  = 1;
   localparam int SYM_ZERO = 0;

   typedef logic [SYM_W-1:0] sym_vec_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ADDR    = 2'd1,
      DATA    = 2'd2,
      WAIT_FE = 2'd3
   } state_t;

   // Number of asserted request lines; only 0, 1 or "more than 1" matters.
   function automatic logic [2:0] count_ones(input sym_vec_t v);
      logic [2:0] n;
      n = '0;
      for (int i = 0; i < SYM_W; i++) begin
         n = n + {2'b00, v[i]};
      end
      return n;
   endfunction
endpackage

// File: rtl/symbol_channel_decoder_if.sv
// Link-side symbol handshake plus the channel drive outputs of the decoder.
// master = symbol source / observer, slave = decoder.
interface symbol_channel_decoder_if #(
   parameter int NUM_CH = 2,
   parameter int MAG_W  = 3
);
   import sym_pkg::*;

   sym_vec_t                sym_req;
   sym_vec_t                sym_ack;
   logic [NUM_CH-1:0]       ch_up;
   logic [NUM_CH-1:0]       ch_down;
   logic [NUM_CH*MAG_W-1:0] ch_mag;
   logic                    frame_done;
   logic                    frame_err;

   modport master (
      output sym_req,
      input  sym_ack, ch_up, ch_down, ch_mag, frame_done, frame_err
   );

   modport slave (
      input  sym_req,
      output sym_ack, ch_up, ch_down, ch_mag, frame_done, frame_err
   );
endinterface

// File: rtl/sym_handshake.sv
// Four-phase symbol handshake: optional input synchroniser (SYNC_IN_EN),
// one-hot / multi-hot classification, accept strobe and per-symbol ack.
module sym_handshake
   import sym_pkg::*;
(
   input  logic     clk,
   input  logic     rst_n,
   input  sym_vec_t sym_req,
   output sym_vec_t sym_ack,
   output logic     sym_valid,
   output logic     multi_err,
   output sym_vec_t sym_sel
);
   sym_vec_t   req_s;
   sym_vec_t   ack_reg;
   sym_vec_t   ack_next;
   logic       ack_idle;
   logic [2:0] req_cnt;

`ifdef SYNC_IN_EN
   genvar gi;
   generate
      for (gi = 0; gi < SYM_W; gi++) begin : g_sync
         logic meta_reg;
         logic sync_reg;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               meta_reg <= 1'b0;
               sync_reg <= 1'b0;
            end else begin
               meta_reg <= sym_req[gi];
               sync_reg <= meta_reg;
            end
         end
         assign req_s[gi] = sync_reg;
      end
   endgenerate
`else
   assign req_s = sym_req;
`endif

   assign req_cnt   = count_ones(req_s);
   assign ack_idle  = (ack_reg == '0);
   assign sym_valid = ack_idle && (req_cnt == 3'd1);
   assign multi_err = ack_idle && (req_cnt > 3'd1);
   assign sym_sel   = req_s;

   // A new request (legal or not) is acked in full; afterwards each ack bit
   // simply follows its request bit down.
   always_comb begin
      ack_next = ack_reg & req_s;
      if (sym_valid || multi_err) begin
         ack_next = req_s;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack_reg <= '0;
      end else begin
         ack_reg <= ack_next;
      end
   end

   assign sym_ack = ack_reg;
endmodule

// File: rtl/symbol_channel_decoder.sv
// Symbol channel decoder: frames FS, address bits, X0, dir+magnitude bits, FE
// and commits the command to one of NUM_CH channel registers. Option: SYNC_IN_EN.
module symbol_channel_decoder
   import sym_pkg::*;
#(
   parameter int NUM_CH = 2,
   parameter int MAG_W  = 3
) (
   input logic                     clk,
   input logic                     rst_n,
   symbol_channel_decoder_if.slave bus
);
   localparam int ADDR_W  = $clog2(NUM_CH);
   localparam int CNT_MAX = (ADDR_W > MAG_W + 1) ? ADDR_W : MAG_W + 1;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [ADDR_W:0] NUM_CH_V = (ADDR_W + 1)'(NUM_CH);

   logic        sym_valid;
   logic        multi_err;
   sym_vec_t    sym_sel;
   logic        is_bit;
   logic        bit_val;
   logic        addr_ok;
   logic        commit_en;

   state_t              state_reg;
   logic [CNT_W-1:0]    cnt_reg;
   logic [ADDR_W-1:0]   addr_reg;
   logic                dir_reg;
   logic [MAG_W-1:0]    mag_reg;
   logic                done_reg;
   logic                err_reg;

   sym_handshake u_handshake (
      .clk       (clk),
      .rst_n     (rst_n),
      .sym_req   (bus.sym_req),
      .sym_ack   (bus.sym_ack),
      .sym_valid (sym_valid),
      .multi_err (multi_err),
      .sym_sel   (sym_sel)
   );

   assign is_bit  = sym_sel[SYM_ONE] | sym_sel[SYM_ZERO];
   assign bit_val = sym_sel[SYM_ONE];
   assign addr_ok = ({1'b0, addr_reg} < NUM_CH_V);

   // Channel registers load on the same edge the FE is accepted.
   assign commit_en = sym_valid && sym_sel[SYM_FE] && (state_reg == WAIT_FE) && addr_ok;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         addr_reg  <= '0;
         dir_reg   <= 1'b0;
         mag_reg   <= '0;
         done_reg  <= 1'b0;
         err_reg   <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         err_reg  <= 1'b0;
         if (multi_err) begin
            err_reg   <= 1'b1;
            state_reg <= IDLE;
         end else if (sym_valid) begin
            if (sym_sel[SYM_FS]) begin
               state_reg <= ADDR;
               cnt_reg   <= '0;
               addr_reg  <= '0;
               dir_reg   <= 1'b0;
               mag_reg   <= '0;
            end else begin
               unique case (state_reg)
                  IDLE: begin
                  end
                  ADDR: begin
                     if (is_bit && (cnt_reg != CNT_W'(ADDR_W))) begin
                        addr_reg <= ADDR_W'({addr_reg, bit_val});
                        cnt_reg  <= cnt_reg + CNT_W'(1);
                     end else if (sym_sel[SYM_X0] && (cnt_reg == CNT_W'(ADDR_W))) begin
                        state_reg <= DATA;
                        cnt_reg   <= '0;
                     end else begin
                        err_reg   <= 1'b1;
                        state_reg <= IDLE;
                     end
                  end
                  DATA: begin
                     if (is_bit) begin
                        if (cnt_reg == '0) begin
                           dir_reg <= bit_val;
                        end else begin
                           mag_reg <= MAG_W'({mag_reg, bit_val});
                        end
                        cnt_reg <= cnt_reg + CNT_W'(1);
                        if (cnt_reg == CNT_W'(MAG_W)) begin
                           state_reg <= WAIT_FE;
                        end
                     end else begin
                        err_reg   <= 1'b1;
                        state_reg <= IDLE;
                     end
                  end
                  WAIT_FE: begin
                     if (sym_sel[SYM_FE] && addr_ok) begin
                        done_reg <= 1'b1;
                     end else begin
                        err_reg <= 1'b1;
                     end
                     state_reg <= IDLE;
                  end
                  default: begin
                     state_reg <= IDLE;
                  end
               endcase
            end
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         logic             up_reg;
         logic             down_reg;
         logic [MAG_W-1:0] mag_ch_reg;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               up_reg     <= 1'b0;
               down_reg   <= 1'b0;
               mag_ch_reg <= '0;
            end else if (commit_en && (addr_reg == ADDR_W'(gi))) begin
               // Zero magnitude stops the channel regardless of direction.
               up_reg     <= dir_reg && (mag_reg != '0);
               down_reg   <= !dir_reg && (mag_reg != '0);
               mag_ch_reg <= mag_reg;
            end
         end

         assign bus.ch_up[gi]                 = up_reg;
         assign bus.ch_down[gi]               = down_reg;
         assign bus.ch_mag[gi*MAG_W +: MAG_W] = mag_ch_reg;
      end
   endgenerate

   assign bus.frame_done = done_reg;
   assign bus.frame_err  = err_reg;
endmodule

// File: tb/tb_symbol_channel_decoder.sv
// Bench for symbol_channel_decoder: a 2-channel and a 3-channel instance driven
// by directed and random symbol frames, checked against a frame-level model.
`timescale 1ns/1ps
module tb_symbol_channel_decoder;
   import sym_pkg::*;

`ifdef SYNC_IN_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif
   localparam int MAG_W = 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   symbol_channel_decoder_if #(.NUM_CH(2), .MAG_W(MAG_W)) bus2 ();
   symbol_channel_decoder_if #(.NUM_CH(3), .MAG_W(MAG_W)) bus3 ();

   symbol_channel_decoder #(.NUM_CH(2), .MAG_W(MAG_W)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
   symbol_channel_decoder #(.NUM_CH(3), .MAG_W(MAG_W)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

   int tests = 0;
   int fails = 0;

   // Model: per DUT, whether a frame is open, the symbols seen since FS,
   // and the committed channel state.
   int m_in  [2];
   int m_len [2];
   int m_sym [2][16];
   int m_up  [2][3];
   int m_dn  [2][3];
   int m_mag [2][3];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      for (int d = 0; d < 2; d++) begin
         m_in[d]  = 0;
         m_len[d] = 0;
         for (int c = 0; c < 3; c++) begin
            m_up[d][c]  = 0;
            m_dn[d][c]  = 0;
            m_mag[d][c] = 0;
         end
      end
   endfunction

   // Legal frame after FS: aw address bits, X0, 1+MAG_W data bits, FE.
   // Any symbol that breaks that pattern is an error and closes the frame.
   function automatic void model_step(input int d, input int sym, output int e_done, output int e_err);
      int  aw;
      int  nch;
      int  pos;
      int  addr;
      int  dir;
      int  mag;
      bit  ok;
      aw     = (d == 0) ? 1 : 2;
      nch    = (d == 0) ? 2 : 3;
      e_done = 0;
      e_err  = 0;
      if (sym < 0) begin
         e_err   = 1;
         m_in[d] = 0;
         return;
      end
      if (sym == SYM_FS) begin
         m_in[d]  = 1;
         m_len[d] = 0;
         return;
      end
      if (m_in[d] == 0) return;
      pos = m_len[d];
      m_sym[d][pos] = sym;
      m_len[d] = pos + 1;
      if (pos < aw || (pos > aw && pos <= aw + 1 + MAG_W))
         ok = (sym == SYM_ONE) || (sym == SYM_ZERO);
      else if (pos == aw)
         ok = (sym == SYM_X0);
      else
         ok = (sym == SYM_FE);
      if (!ok) begin
         e_err   = 1;
         m_in[d] = 0;
         return;
      end
      if (pos == aw + 2 + MAG_W) begin
         m_in[d] = 0;
         addr = 0;
         for (int i = 0; i < aw; i++) addr = addr * 2 + ((m_sym[d][i] == SYM_ONE) ? 1 : 0);
         dir = (m_sym[d][aw + 1] == SYM_ONE) ? 1 : 0;
         mag = 0;
         for (int i = 0; i < MAG_W; i++) mag = mag * 2 + ((m_sym[d][aw + 2 + i] == SYM_ONE) ? 1 : 0);
         if (addr >= nch) begin
            e_err = 1;
         end else begin
            e_done = 1;
            m_mag[d][addr] = mag;
            m_up[d][addr]  = (dir == 1 && mag != 0) ? 1 : 0;
            m_dn[d][addr]  = (dir == 0 && mag != 0) ? 1 : 0;
         end
      end
   endfunction

   task automatic exp_vecs(input int d, output logic [31:0] up, output logic [31:0] dn, output logic [31:0] mag);
      up  = '0;
      dn  = '0;
      mag = '0;
      for (int c = 0; c < ((d == 0) ? 2 : 3); c++) begin
         up  = up  | (32'(m_up[d][c])  << c);
         dn  = dn  | (32'(m_dn[d][c])  << c);
         mag = mag | (32'(m_mag[d][c]) << (c * MAG_W));
      end
   endtask

   task automatic get_obs(input int d, output logic [31:0] ack, output logic [31:0] up,
                          output logic [31:0] dn, output logic [31:0] mag,
                          output logic [31:0] done, output logic [31:0] err);
      if (d == 0) begin
         ack = 32'(bus2.sym_ack);  up = 32'(bus2.ch_up);  dn = 32'(bus2.ch_down);
         mag = 32'(bus2.ch_mag);   done = 32'(bus2.frame_done); err = 32'(bus2.frame_err);
      end else begin
         ack = 32'(bus3.sym_ack);  up = 32'(bus3.ch_up);  dn = 32'(bus3.ch_down);
         mag = 32'(bus3.ch_mag);   done = 32'(bus3.frame_done); err = 32'(bus3.frame_err);
      end
   endtask

   task automatic set_req(input int d, input logic [4:0] v);
      if (d == 0) bus2.sym_req = v;
      else        bus3.sym_req = v;
   endtask

   function automatic logic [4:0] enc(input byte c);
      case (c)
         "F":     return 5'b10000;
         "X":     return 5'b01000;
         "E":     return 5'b00100;
         "1":     return 5'b00010;
         "0":     return 5'b00001;
         default: return 5'b00011;
      endcase
   endfunction

   function automatic string bitc(input int b);
      return (b != 0) ? "1" : "0";
   endfunction

   // One full four-phase handshake plus output checks on the ack sample.
   task automatic send(input int d, input logic [4:0] req, input int hold, input string tag);
      int cyc;
      int sym;
      int e_done;
      int e_err;
      logic [31:0] ack, up, dn, mag, done, err, eu, ed, em;
      sym = -1;
      if ($countones(req) == 1)
         for (int i = 0; i < 5; i++) if (req[i]) sym = i;
      set_req(d, req);
      cyc = 0;
      do begin
         @(posedge clk); #1;
         cyc++;
         get_obs(d, ack, up, dn, mag, done, err);
      end while (ack != 32'(req) && cyc < 20);
      chk({tag, " ack_rise_lat"}, 32'(cyc), 32'(LAT));
      chk({tag, " ack"}, ack, 32'(req));
      model_step(d, sym, e_done, e_err);
      exp_vecs(d, eu, ed, em);
      chk({tag, " frame_done"}, done, 32'(e_done));
      chk({tag, " frame_err"}, err, 32'(e_err));
      chk({tag, " ch_up"}, up, eu);
      chk({tag, " ch_down"}, dn, ed);
      chk({tag, " ch_mag"}, mag, em);
      if (hold > 0) begin
         repeat (hold) begin
            @(posedge clk); #1;
         end
         get_obs(d, ack, up, dn, mag, done, err);
         chk({tag, " ack_held"}, ack, 32'(req));
      end
      set_req(d, 5'b0);
      cyc = 0;
      do begin
         @(posedge clk); #1;
         cyc++;
         get_obs(d, ack, up, dn, mag, done, err);
      end while (ack != 0 && cyc < 20);
      chk({tag, " ack_fall_lat"}, 32'(cyc), 32'(LAT));
      chk({tag, " pulse_clear"}, {done[15:0], err[15:0]}, 32'h0);
   endtask

   // hold < 0 picks a random hold per symbol.
   task automatic run_str(input int d, input string s, input int hold, input string tag);
      $display("[TB] %s dut%0d frame %s", tag, d, s);
      for (int i = 0; i < s.len(); i++) begin
         send(d, enc(s.getc(i)), (hold < 0) ? $urandom_range(0, 3) : hold,
              $sformatf("%s[%0d]", tag, i));
      end
   endtask

   task automatic check_all_zero(input string tag);
      logic [31:0] ack, up, dn, mag, done, err;
      for (int d = 0; d < 2; d++) begin
         get_obs(d, ack, up, dn, mag, done, err);
         chk($sformatf("%s dut%0d outputs", tag, d), ack | up | dn | mag | done | err, 32'h0);
      end
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog timeout tests=%0d", tests);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ack, up, dn, mag, done, err;
      string s;
      string junk;
      int d;
      int aw;
      int pos;
      junk = "FXE10M";
      bus2.sym_req = '0;
      bus3.sym_req = '0;
      model_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst_n = 1'b1;

      // Single frame to channel 1 up 5, then stop it; channel 0 untouched.
      run_str(0, "F1X1101E", 0, "up5");
      get_obs(0, ack, up, dn, mag, done, err);
      chk("up5 direct ch_up", up, 32'h2);
      chk("up5 direct ch_mag1", (mag >> 3) & 32'h7, 32'd5);
      run_str(0, "F1X0000E", 0, "stop");
      get_obs(0, ack, up, dn, mag, done, err);
      chk("stop direct up|dn", up | dn, 32'h0);
      chk("stop direct mag", mag, 32'h0);

      // Restart via FS mid-frame, then channel 0 down 1.
      run_str(0, "F1F0X0001E", 0, "restart");
      get_obs(0, ack, up, dn, mag, done, err);
      chk("restart direct ch_down", dn, 32'h1);
      chk("restart direct ch_mag0", mag & 32'h7, 32'd1);

      // Three-channel instance: out-of-range address and early X0.
      run_str(1, "F10X1011E", 0, "ch2");
      run_str(1, "F11X1011E", 0, "badaddr");
      run_str(1, "F1X", 0, "earlyx0");
      run_str(1, "F01X0E", 0, "earlyfe");

      // Long hold and multi-hot request mid-frame (drops back to IDLE).
      run_str(0, "F1X1", 5, "hold5");
      send(0, 5'b00011, 2, "multihot");
      run_str(0, "X0E", 0, "idle_ignore");

      // Reset in the middle of a frame, then a normal frame.
      run_str(0, "F0X1111E", 0, "pre_rst");
      run_str(0, "F1", 0, "mid_rst");
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_all_zero("mid_reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      run_str(0, "F1X1011E", 0, "post_rst");

      // Random frames, occasionally corrupted by one random symbol.
      for (int k = 0; k < 40; k++) begin
         d  = k % 2;
         aw = (d == 0) ? 1 : 2;
         s  = "F";
         for (int i = 0; i < aw; i++) s = {s, bitc($urandom_range(0, 1))};
         s = {s, "X"};
         for (int i = 0; i < 1 + MAG_W; i++) s = {s, bitc($urandom_range(0, 1))};
         s = {s, "E"};
         if ($urandom_range(0, 4) == 0) begin
            pos = $urandom_range(1, s.len() - 1);
            s.putc(pos, junk.getc($urandom_range(0, 5)));
         end
         run_str(d, s, -1, $sformatf("rnd%0d", k));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
